// File: rtl/i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_ctrl
//   Single-master I2C controller. On a start request it emits START, the
//   7-bit address plus R/W, num_bytes data bytes (write or read), then STOP,
//   on an open-drain SCL/SDA pair. Slave clock stretching is honoured.
//
//   Bit timing: every bit spans four quarters of QDIV clk cycles each.
//     Q0 : SCL low (SDA was updated at the Q3->Q0 boundary)
//     Q1 : SCL released; the quarter counter holds at 0 until SCL reads high
//     Q2 : SCL high; SDA sampled at the end of the quarter
//     Q3 : SCL pulled low; state advances at the end of the quarter
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   start               one-cycle request, accepted only while idle
//   addr, read_nwrite   slave address and direction, latched on accept
//   num_bytes           data byte count (0 = address-only probe)
//   data_i / data_req   write data; data_req pulses when data_i is taken
//   data_o / data_valid last read byte; data_valid pulses on update
//   busy                accepted start through end of STOP
//   nack                sticky slave NACK flag, cleared by next accept
//   SCL, SDA            open-drain bus lines (driven 0 or Z only)
// ---------------------------------------------------------------------------
module i2c_master_ctrl #(
  parameter int QDIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       read_nwrite,
  input  logic [3:0] num_bytes,
  input  logic [7:0] data_i,
  output logic       data_req,
  output logic [7:0] data_o,
  output logic       data_valid,
  output logic       busy,
  output logic       nack,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam int QW = $clog2(QDIV);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
    S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    qtr;
  logic [2:0]    bit_cnt;
  logic [3:0]    byte_cnt;
  logic          rw;
  logic          samp;
  logic          scl_oe;
  logic          sda_oe;
  logic [7:0]    shreg;
  logic [7:0]    wbuf;
  logic [7:0]    rx;

  logic          scl_p0, scl_p1;
  logic          sda_p0, sda_p1;

  logic          accept;
  logic          stretch_hold;
  logic          tick;
  logic          q2_tick;
  logic          q3_tick;

  assign SCL = scl_oe ? 1'b0 : 1'bz;
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Bus input synchronisers: _p0 first flop, _p1 usable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= SCL;
      scl_p1 <= scl_p0;
      sda_p0 <= SDA;
      sda_p1 <= sda_p0;
    end
  end

  assign accept       = (state == S_IDLE) && start;
  // In Q1 the line has been released; a slave holding it low freezes time.
  assign stretch_hold = (qtr == 2'd1) && !scl_p1;
  assign tick         = (state != S_IDLE) && !stretch_hold && (qcnt == QW'(QDIV - 1));
  assign q2_tick      = tick && (qtr == 2'd2);
  assign q3_tick      = tick && (qtr == 2'd3);

  // Control path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      qcnt       <= '0;
      qtr        <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rw         <= 1'b0;
      samp       <= 1'b1;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      nack       <= 1'b0;
      data_req   <= 1'b0;
      data_valid <= 1'b0;
      data_o     <= '0;
    end else begin
      data_req   <= 1'b0;
      data_valid <= 1'b0;

      if (state == S_IDLE) begin
        qcnt <= '0;
        qtr  <= '0;
        if (start) begin
          rw       <= read_nwrite;
          byte_cnt <= num_bytes;
          bit_cnt  <= '0;
          nack     <= 1'b0;
          busy     <= 1'b1;
          data_req <= 1'b1;
          state    <= S_START;
        end
      end else begin
        if (stretch_hold) begin
          qcnt <= '0;
        end else if (tick) begin
          qcnt <= '0;
          qtr  <= qtr + 2'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end

        if (tick) begin
          case (qtr)
            2'd0: scl_oe <= 1'b0;
            // START condition: SDA falls while SCL is high.
            2'd1: if (state == S_START) sda_oe <= 1'b1;
            2'd2: begin
              samp <= sda_p1;
              // STOP condition: SDA rises while SCL stays high.
              if (state == S_STOP) sda_oe <= 1'b0;
              else                 scl_oe <= 1'b1;
            end
            default: begin
              case (state)
                S_START: begin
                  state  <= S_ADDR;
                  sda_oe <= ~shreg[7];
                end
                S_ADDR: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    state  <= S_ADDR_ACK;
                    sda_oe <= 1'b0;
                  end else begin
                    sda_oe <= ~shreg[6];
                  end
                end
                S_ADDR_ACK: begin
                  if (samp) begin
                    nack   <= 1'b1;
                    state  <= S_STOP;
                    sda_oe <= 1'b1;
                  end else if (byte_cnt == 4'd0) begin
                    state  <= S_STOP;
                    sda_oe <= 1'b1;
                  end else if (rw) begin
                    state  <= S_READ;
                    sda_oe <= 1'b0;
                  end else begin
                    state  <= S_WRITE;
                    sda_oe <= ~wbuf[7];
                  end
                end
                S_WRITE: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    state  <= S_WRITE_ACK;
                    sda_oe <= 1'b0;
                  end else begin
                    sda_oe <= ~shreg[6];
                  end
                end
                S_WRITE_ACK: begin
                  if (samp) begin
                    nack   <= 1'b1;
                    state  <= S_STOP;
                    sda_oe <= 1'b1;
                  end else begin
                    if (byte_cnt != 4'd0) byte_cnt <= byte_cnt - 4'd1;
                    if (byte_cnt <= 4'd1) begin
                      state  <= S_STOP;
                      sda_oe <= 1'b1;
                    end else begin
                      state    <= S_WRITE;
                      sda_oe   <= ~data_i[7];
                      data_req <= 1'b1;
                    end
                  end
                end
                S_READ: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    data_o     <= rx;
                    data_valid <= 1'b1;
                    if (byte_cnt != 4'd0) byte_cnt <= byte_cnt - 4'd1;
                    state      <= S_READ_ACK;
                    // ACK (drive low) while more bytes follow, NACK on the last.
                    sda_oe     <= (byte_cnt > 4'd1);
                  end
                end
                S_READ_ACK: begin
                  if (byte_cnt == 4'd0) begin
                    state  <= S_STOP;
                    sda_oe <= 1'b1;
                  end else begin
                    state  <= S_READ;
                    sda_oe <= 1'b0;
                  end
                end
                S_STOP: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
                default: state <= S_IDLE;
              endcase
            end
          endcase
        end
      end
    end
  end

  // Data path: shift/load registers, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {addr, read_nwrite};
      wbuf  <= data_i;
    end else if (q3_tick) begin
      case (state)
        S_ADDR, S_WRITE: shreg <= {shreg[6:0], 1'b0};
        S_ADDR_ACK:      shreg <= wbuf;
        S_WRITE_ACK:     shreg <= data_i;
        default:         shreg <= shreg;
      endcase
    end
    if (q2_tick && (state == S_READ)) rx <= {rx[6:0], sda_p1};
  end

endmodule
